// File: rtl/floppy_pkg.sv
// Shared constants, FSM state type and LBA helper for the floppy track buffer.
package floppy_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int TRACK_BYTES  = 6656;
    localparam int NUM_TRACKS   = 35;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_REQ,
        ST_LOAD_XFER,
        ST_FLUSH_REQ,
        ST_FLUSH_XFER
    } ftb_state_t;

    function automatic logic [31:0] sector_lba(input logic [5:0] trk, input logic [3:0] sec,
                                               input int spt);
        return 32'(trk) * 32'(spt) + 32'(sec);
    endfunction

endpackage

// File: rtl/floppy_track_buffer_ram.sv
// True dual-port byte RAM holding one nibble track; port A controller, port B SD host.
// Latency: registered reads, data one cycle after address on both ports.
// Backpressure: none, both ports accept an access every cycle.
module track_ram
    import floppy_pkg::*;
#(
    parameter int DEPTH = TRACK_BYTES
) (
    input  logic       CLK_14M,
    input  logic [12:0] a_addr,
    input  logic       a_we,
    input  logic [7:0] a_din,
    output logic [7:0] a_dout,
    input  logic [12:0] b_addr,
    input  logic       b_we,
    input  logic [7:0] b_din,
    output logic [7:0] b_dout
);

    logic [7:0] mem [0:DEPTH-1];

    // Both ports in one process so the array has a single driver; read returns old data.
    always_ff @(posedge CLK_14M) begin
        if (a_we) mem[a_addr] <= a_din;
        if (b_we) mem[b_addr] <= b_din;
        a_dout <= mem[a_addr];
        b_dout <= mem[b_addr];
    end

endmodule

// File: rtl/floppy_track_buffer.sv
// Per-drive nibble-track cache fed from the SD host; FLOPPY_WRITEBACK_EN adds flush of dirty tracks.
// Latency: TRACK_DO one cycle after TRACK_ADDR; a track load takes 13 SD sector transfers.
// Backpressure: TRACK_BUSY high while loading/flushing; controller writes are dropped then.
module floppy_track_buffer
    import floppy_pkg::*;
#(
    parameter int SECTORS_PER_TRACK = 13,
    parameter int NUM_TRACKS        = 35
) (
    input  logic        CLK_14M,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [5:0]  TRACK,
    input  logic [12:0] TRACK_ADDR,
    input  logic [7:0]  TRACK_DI,
    input  logic        TRACK_WE,
    output logic [7:0]  TRACK_DO,
    output logic        TRACK_BUSY,
    output logic        DISK_READY,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    output logic [7:0]  sd_buff_din,
    input  logic        sd_buff_wr
);

    localparam int         TRK_BYTES = SECTORS_PER_TRACK * SECTOR_BYTES;
    localparam logic [5:0] NO_TRACK  = 6'h3F;
    localparam logic [3:0] LAST_SEC  = 4'(SECTORS_PER_TRACK - 1);

    ftb_state_t  state, state_nxt;
    logic [3:0]  sec, sec_nxt;
    logic [5:0]  load_trk, load_trk_nxt;
    logic [5:0]  loaded_track, loaded_track_nxt;
    logic        busy_nxt, ready_nxt, rd_nxt, wr_nxt;
    logic [31:0] lba_nxt;
    logic        ack_d, ack_fall;
    logic        track_ok, want_load, ctl_wr, addr_oob_q;
    logic [12:0] b_addr;
    logic        b_we;
    logic [7:0]  a_dout, b_dout;
`ifdef FLOPPY_WRITEBACK_EN
    logic        dirty, dirty_nxt;
`else
    logic        wb_unused;
    // Read-only flag and SD-side read data only matter when flushing.
    assign wb_unused = img_readonly ^ (^b_dout);
`endif

    assign track_ok = TRACK < 6'(NUM_TRACKS);
    assign ack_fall = ack_d & ~sd_ack;
    assign ctl_wr   = TRACK_WE && (state == ST_IDLE) && !TRACK_BUSY
                      && (TRACK_ADDR < 13'(TRK_BYTES));
    // Host must be idle too, so a fresh request never starts under a stale sd_ack.
    assign want_load = DISK_READY && (TRACK != loaded_track) && track_ok && !sd_ack;

    // Sector size is a power of two, so the SD-side address is a plain concatenation.
    assign b_addr = {sec, sd_buff_addr};
    assign b_we   = (state == ST_LOAD_XFER) && sd_buff_wr && !reset;

    assign TRACK_DO = addr_oob_q ? 8'hFF : a_dout;
`ifdef FLOPPY_WRITEBACK_EN
    assign sd_buff_din = b_dout;
`else
    assign sd_buff_din = 8'h00;
`endif

    track_ram #(.DEPTH(TRK_BYTES)) u_ram (
        .CLK_14M (CLK_14M),
        .a_addr  (TRACK_ADDR),
        .a_we    (ctl_wr),
        .a_din   (TRACK_DI),
        .a_dout  (a_dout),
        .b_addr  (b_addr),
        .b_we    (b_we),
        .b_din   (sd_buff_dout),
        .b_dout  (b_dout)
    );

    always_comb begin
        state_nxt        = state;
        sec_nxt          = sec;
        load_trk_nxt     = load_trk;
        loaded_track_nxt = loaded_track;
        busy_nxt         = TRACK_BUSY;
        ready_nxt        = DISK_READY;
        rd_nxt           = 1'b0;
        wr_nxt           = 1'b0;
        lba_nxt          = sd_lba;
`ifdef FLOPPY_WRITEBACK_EN
        dirty_nxt = dirty;
        if (ctl_wr && !img_readonly) dirty_nxt = 1'b1;
        if (img_mounted) dirty_nxt = 1'b0;
`endif
        if (img_mounted) begin
            ready_nxt        = 1'b1;
            loaded_track_nxt = NO_TRACK;
        end

        case (state)
            ST_IDLE: begin
                if (want_load && !img_mounted) begin
                    busy_nxt     = 1'b1;
                    sec_nxt      = 4'd0;
                    load_trk_nxt = TRACK;
                    state_nxt    = ST_LOAD_REQ;
                    lba_nxt      = sector_lba(TRACK, 4'd0, SECTORS_PER_TRACK);
`ifdef FLOPPY_WRITEBACK_EN
                    // Nothing to write back while no valid track is resident.
                    if (dirty && (loaded_track < 6'(NUM_TRACKS))) begin
                        state_nxt = ST_FLUSH_REQ;
                        lba_nxt   = sector_lba(loaded_track, 4'd0, SECTORS_PER_TRACK);
                    end
`endif
                end
            end
            ST_LOAD_REQ: begin
                if (sd_ack) state_nxt = ST_LOAD_XFER;
                else        rd_nxt    = 1'b1;
            end
            ST_LOAD_XFER: begin
                if (ack_fall) begin
                    if (track_ok && (TRACK != load_trk)) begin
                        sec_nxt      = 4'd0;
                        load_trk_nxt = TRACK;
                        state_nxt    = ST_LOAD_REQ;
                        lba_nxt      = sector_lba(TRACK, 4'd0, SECTORS_PER_TRACK);
                    end else if (sec == LAST_SEC) begin
                        loaded_track_nxt = load_trk;
                        busy_nxt         = 1'b0;
                        state_nxt        = ST_IDLE;
                    end else begin
                        sec_nxt   = sec + 4'd1;
                        state_nxt = ST_LOAD_REQ;
                        lba_nxt   = sector_lba(load_trk, sec + 4'd1, SECTORS_PER_TRACK);
                    end
                end
            end
`ifdef FLOPPY_WRITEBACK_EN
            ST_FLUSH_REQ: begin
                if (sd_ack) begin
                    state_nxt = ST_FLUSH_XFER;
                end else if (!dirty) begin
                    // A remount discarded the write-back before the host picked it up.
                    sec_nxt   = 4'd0;
                    state_nxt = ST_LOAD_REQ;
                    lba_nxt   = sector_lba(load_trk, 4'd0, SECTORS_PER_TRACK);
                end else begin
                    wr_nxt = 1'b1;
                end
            end
            ST_FLUSH_XFER: begin
                if (ack_fall) begin
                    if ((sec == LAST_SEC) || !dirty) begin
                        dirty_nxt = 1'b0;
                        sec_nxt   = 4'd0;
                        if (track_ok) load_trk_nxt = TRACK;
                        state_nxt = ST_LOAD_REQ;
                        lba_nxt   = sector_lba(track_ok ? TRACK : load_trk, 4'd0,
                                               SECTORS_PER_TRACK);
                    end else begin
                        sec_nxt   = sec + 4'd1;
                        state_nxt = ST_FLUSH_REQ;
                        lba_nxt   = sector_lba(loaded_track, sec + 4'd1, SECTORS_PER_TRACK);
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_14M) begin
        if (reset) begin
            state        <= ST_IDLE;
            sec          <= 4'd0;
            load_trk     <= 6'd0;
            loaded_track <= NO_TRACK;
            TRACK_BUSY   <= 1'b0;
            DISK_READY   <= 1'b0;
            sd_rd        <= 1'b0;
            sd_wr        <= 1'b0;
            sd_lba       <= 32'd0;
            ack_d        <= 1'b0;
            addr_oob_q   <= 1'b0;
`ifdef FLOPPY_WRITEBACK_EN
            dirty        <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            sec          <= sec_nxt;
            load_trk     <= load_trk_nxt;
            loaded_track <= loaded_track_nxt;
            TRACK_BUSY   <= busy_nxt;
            DISK_READY   <= ready_nxt;
            sd_rd        <= rd_nxt;
            sd_wr        <= wr_nxt;
            sd_lba       <= lba_nxt;
            ack_d        <= sd_ack;
            addr_oob_q   <= TRACK_ADDR >= 13'(TRK_BYTES);
`ifdef FLOPPY_WRITEBACK_EN
            dirty        <= dirty_nxt;
`endif
        end
    end

endmodule
